// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/adder_cl.sv
// N-bit unsigned adder with carry-in/carry-out; the multiplier's only arithmetic element.
module adder_cl #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N-1:0] g;
    logic [N-1:0] pr;
    logic         carry;

    assign g  = a & b;
    assign pr = a ^ b;

    // The carry travels in a scalar so the chain does not feed back through a vector.
    always_comb begin
        s     = '0;
        carry = ci;
        for (int i = 0; i < N; i++) begin
            s[i]  = pr[i] ^ carry;
            carry = g[i] | (pr[i] & carry);
        end
        co = carry;
    end
endmodule

// File: rtl/mult_sa.sv
// Sequential N x N -> 2N unsigned shift-and-add multiplier, one product per operation.
// Handshake: start is taken only in IDLE; busy covers RUN and DONE; done pulses one cycle with p valid from then on.
module mult_sa
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p,
    output logic [1:0]     dbg_state
);
    localparam int CW = $clog2(N + 1);

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    m_r;
    logic [N-1:0]    a_r;
    logic [N-1:0]    q_r;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    add_s;
    logic            add_co;
    logic [N:0]      sum;
    logic            last;

    adder_cl #(.N(N)) u_add (
        .a  (a_r),
        .b  (m_r),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

    // {C,A} for this iteration; C is zero again after the shift, so it lives only in sum[N].
    assign sum  = q_r[0] ? {add_co, add_s} : {1'b0, a_r};
    assign last = (cnt == CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_r  <= '0;
            a_r  <= '0;
            q_r  <= '0;
            cnt  <= '0;
            p    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r <= a;
                        q_r <= b;
                        a_r <= '0;
                        cnt <= CW'(N);
                    end
                end
                RUN: begin
                    a_r <= sum[N:1];
                    q_r <= {sum[0], q_r[N-1:1]};
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        p    <= {sum[N:1], sum[0], q_r[N-1:1]};
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
endmodule
